serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 23 ++
 rtl/serial_add_ctrl_if.sv | 33 +++
 rtl/serial_add_ctrl_add4.sv | 12 +
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the nibble-serial adder: state encoding, slice width, counter sizing.
package serial_add_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Width of the nibble counter; at least one bit so the vector is never empty.
    function automatic int cnt_w(input int width);
        int n;
        n = width / SLICE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side start/done bus of serial_add_ctrl. Optional `sub` with SERIAL_ADD_SUB_EN.
interface serial_add_ctrl_if #(parameter int WIDTH = 16);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, ci,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, a, b, ci,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        output busy, done, s, co, ovf
    );

endinterface

// File: rtl/serial_add_ctrl_add4.sv
// Purely combinational 4-bit adder slice shared by the serial controller.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder sequencing one add4 slice over WIDTH/4 nibbles, LSB first.
// Build with SERIAL_ADD_SUB_EN to add the `sub` port (a - b via ~b + 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int CW  = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSL - 1);

    state_t state, state_nx;

    logic [WIDTH-1:0]   a_q, b_q, s_q;
    logic               carry_q, co_q, ovf_q;
    logic [CW-1:0]      cnt;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_co;
    logic               accept, last;
    logic [WIDTH-1:0]   b_in;
    logic               ci_in;

    assign accept = (state == S_IDLE) && bus.start;
    assign last   = (state == S_RUN) && (cnt == CNT_LAST);

`ifdef SERIAL_ADD_SUB_EN
    assign b_in  = bus.sub ? ~bus.b : bus.b;
    assign ci_in = bus.sub ? 1'b1   : bus.ci;
`else
    assign b_in  = bus.b;
    assign ci_in = bus.ci;
`endif

    assign sl_a = a_q[SLICE_W*cnt +: SLICE_W];
    assign sl_b = b_q[SLICE_W*cnt +: SLICE_W];

    add4 u_add4 (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= b_in;
            carry_q <= ci_in;
            cnt     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == S_RUN) begin
            s_q[SLICE_W*cnt +: SLICE_W] <= sl_s;
            carry_q <= sl_co;
            // Counter parks on the last nibble; the next start reloads it.
            if (!last) cnt <= cnt + CW'(1);
            if (last) begin
                co_q  <= sl_co;
                ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE_W-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=16) against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NSL = W / 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    logic m_sub;
`ifdef SERIAL_ADD_SUB_EN
    assign m_sub = bus.sub;
`else
    assign m_sub = 1'b0;
`endif

    // {ovf, co, s} straight from the arithmetic definition.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic ci, input logic sub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        logic         ov;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    // ph: 0 idle, 1..NSL computing, NSL+1 result cycle.
    int           ph;
    logic [W-1:0] m_s, p_s;
    logic         m_co, m_ovf, p_co, p_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0; m_s <= '0; m_co <= 1'b0; m_ovf <= 1'b0;
            p_s <= '0; p_co <= 1'b0; p_ovf <= 1'b0;
        end else if (ph == 0) begin
            if (bus.start) begin
                {p_ovf, p_co, p_s} <= model_op(bus.a, bus.b, bus.ci, m_sub);
                m_s <= '0; m_co <= 1'b0; m_ovf <= 1'b0;
                ph <= 1;
            end
        end else if (ph <= NSL) begin
            ph <= ph + 1;
            if (ph == NSL) {m_ovf, m_co, m_s} <= {p_ovf, p_co, p_s};
        end else begin
            ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", 32'(bus.busy), 32'(ph != 0));
            chk("done", 32'(bus.done), 32'(ph == NSL + 1));
            chk("co",   32'(bus.co),   32'(m_co));
            chk("ovf",  32'(bus.ovf),  32'(m_ovf));
            if (ph == 0 || ph == NSL + 1) chk("s", 32'(bus.s), 32'(m_s));
        end
    end

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub,
                          input logic [W-1:0] es, input logic eco, input logic eovf);
        int  k;
        bit  got;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.ci = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sub;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.ci = 1'($urandom);
        k = 1; got = 1'b0;
        while (!got && k < 12) begin
            if (bus.done) got = 1'b1;
            else begin @(negedge clk); k++; end
        end
        chk({nm, "_latency"}, 32'(k), 32'(5));
        chk({nm, "_s"},   32'(bus.s),   32'(es));
        chk({nm, "_co"},  32'(bus.co),  32'(eco));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eovf));
        @(negedge clk);
        chk({nm, "_done_width"}, 32'(bus.done), 32'(0));
    endtask

    initial begin
        int n_done;
        logic [W-1:0] s_at_done;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b0;
`endif
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_s",    32'(bus.s),    0);
        chk("rst_co",   32'(bus.co),   0);
        chk("rst_ovf",  32'(bus.ovf),  0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("pos_ovf",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_pos",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // A second start while busy must be dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.ci = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b0;
`endif
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0001;
        @(negedge clk); bus.start = 1'b0;
        n_done = 0; s_at_done = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin n_done++; s_at_done = bus.s; end
            @(negedge clk);
        end
        chk("ignore_ndone", 32'(n_done), 1);
        chk("ignore_s", 32'(s_at_done), 32'h0003);

        // Reset after two nibbles aborts with everything cleared at once.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.ci = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_s",    32'(bus.s),    0);
        chk("abort_co",   32'(bus.co),   0);
        chk("abort_ovf",  32'(bus.ovf),  0);
        @(negedge clk);
        #2 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 0);

        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
